// File: rtl/mem_pkg.sv
// Shared definitions for the banked byte memory and the engines that drive its port.
package mem_pkg;

    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 8;

    typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
    typedef logic [MEM_DATA_W-1:0] mem_data_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WRITE  = 3'd2,
        VERIFY = 3'd3,
        DONE   = 3'd4
    } copy_state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Forward byte-by-byte memory copy engine driving a single-port memory directly.
// Optional read-back check of every written byte is enabled with MEM_COPY_VERIFY_EN.
module mem_copy_engine
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(1) << ADDR_W;

    copy_state_e       state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]  count;
    logic [DATA_W-1:0] data_reg;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if ({1'b0, len} > MAX_LEN)
            return MAX_LEN[LEN_W-1:0];
        return len;
    endfunction

`ifdef MEM_COPY_VERIFY_EN
    logic [ADDR_W-1:0] last_dst;
    logic              err_reg;
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    // Control outputs decode registered state only, so mem_wen cannot glitch
    // and drops as soon as the asynchronous reset forces IDLE.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state == READ) || (state == WRITE) || (state == VERIFY);
    assign done      = (state == DONE);
    assign mem_wen   = (state == WRITE);
    assign mem_wdata = data_reg;

    always_comb begin
        mem_addr = '0;
        case (state)
            READ:    mem_addr = src_ptr;
            WRITE:   mem_addr = dst_ptr;
`ifdef MEM_COPY_VERIFY_EN
            VERIFY:  mem_addr = last_dst;
`endif
            default: mem_addr = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            src_ptr  <= '0;
            dst_ptr  <= '0;
            count    <= '0;
            data_reg <= '0;
`ifdef MEM_COPY_VERIFY_EN
            last_dst <= '0;
            err_reg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        src_ptr <= cmd_src;
                        dst_ptr <= cmd_dst;
                        count   <= clamp_len(cmd_len);
`ifdef MEM_COPY_VERIFY_EN
                        err_reg <= 1'b0;
`endif
                        state   <= (cmd_len == '0) ? DONE : READ;
                    end
                end
                READ: begin
                    data_reg <= mem_rdata;
                    state    <= WRITE;
                end
                WRITE: begin
                    src_ptr <= src_ptr + ADDR_W'(1);
                    dst_ptr <= dst_ptr + ADDR_W'(1);
                    count   <= count - LEN_W'(1);
`ifdef MEM_COPY_VERIFY_EN
                    last_dst <= dst_ptr;
                    state    <= VERIFY;
`else
                    state   <= (count == LEN_W'(1)) ? DONE : READ;
`endif
                end
`ifdef MEM_COPY_VERIFY_EN
                // Count was already decremented in WRITE.
                VERIFY: begin
                    if (mem_rdata != data_reg)
                        err_reg <= 1'b1;
                    state <= (count == '0) ? DONE : READ;
                end
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Randomized self-checking bench for mem_copy_engine with a behavioural memory and copy model.
module tb_mem_copy_engine;

`ifdef MEM_COPY_VERIFY_EN
    localparam int CPB = 3;
`else
    localparam int CPB = 2;
`endif
    localparam int MSIZE = 1024;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_src;
    logic [9:0]  cmd_dst;
    logic [10:0] cmd_len;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_wen;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem     [MSIZE];
    logic [7:0]  ref_mem [MSIZE];
    logic [9:0]  wr_log  [4096];
    int          wen_count;
    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [7:0]  pl_data;
    logic        bad_bank2;

    int n_checks;
    int n_fail;

    mem_copy_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_len   (cmd_len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural memory: combinational read, posedge write, backdoor preload port.
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_wen) begin
            if (bad_bank2 && mem_addr[9:8] == 2'd2)
                mem[mem_addr] <= ~mem_wdata;
            else
                mem[mem_addr] <= mem_wdata;
            wr_log[wen_count % 4096] <= mem_addr;
            wen_count <= wen_count + 1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic preload(input int addr, input int data);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = 10'(addr);
        pl_data = 8'(data);
        ref_mem[addr] = 8'(data);
    endtask

    task automatic preload_done();
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic compare_mem();
        int diff;
        diff = 0;
        for (int i = 0; i < MSIZE; i++)
            if (mem[i] !== ref_mem[i]) diff++;
        check("mem_image", diff, 0);
    endtask

    // Reference: a forward copy one byte at a time, addresses modulo memory size.
    task automatic model_copy(input int src, input int dst, input int n);
        for (int i = 0; i < n; i++)
            ref_mem[(dst + i) % MSIZE] = ref_mem[(src + i) % MSIZE];
    endtask

    task automatic run_copy(input int src, input int dst, input int len, input bit hold,
                            input bit exp_err, input bit cmp_mem);
        int n, edges, w0, bad;
        n = (len > MSIZE) ? MSIZE : len;
        @(negedge clk);
        check("ready_idle", int'(cmd_ready), 1);
        cmd_src   = 10'(src);
        cmd_dst   = 10'(dst);
        cmd_len   = 11'(len);
        cmd_valid = 1'b1;
        w0 = wen_count;
        @(posedge clk);
        #1;
        if (hold) begin
            cmd_src = ~cmd_src;
            cmd_dst = ~cmd_dst;
            cmd_len = 11'd7;
        end else begin
            cmd_valid = 1'b0;
        end
        check("busy_after_accept", int'(busy), int'(n > 0));
        edges = 0;
        while (done !== 1'b1 && edges <= n * CPB + 4) begin
            @(posedge clk);
            #1;
            edges++;
        end
        cmd_valid = 1'b0;
        check("done_latency", edges, n * CPB);
        check("busy_at_done", int'(busy), 0);
        check("err_at_done", int'(err), int'(exp_err));
        check("wen_cycles", wen_count - w0, n);
        @(posedge clk);
        #1;
        check("done_pulse", int'(done), 0);
        check("ready_after", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        check("no_extra_wen", wen_count - w0, n);
        bad = 0;
        for (int i = 0; i < n; i++)
            if (wr_log[(w0 + i) % 4096] !== 10'((dst + i) % MSIZE)) bad++;
        check("write_addrs", bad, 0);
        if (!exp_err) model_copy(src, dst, n);
        if (cmp_mem) compare_mem();
    endtask

    initial begin
        int idle_wen, w0, src, dst, len;
        logic [7:0] byte1, old2;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_src   = '0;
        cmd_dst   = '0;
        cmd_len   = '0;
        pl_en     = 1'b0;
        pl_addr   = '0;
        pl_data   = '0;
        bad_bank2 = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_wen", int'(mem_wen), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_wdata", int'(mem_wdata), 0);
        check("rst_err", int'(err), 0);

        for (int i = 0; i < MSIZE; i++) preload(i, $urandom_range(0, 255));
        preload_done();

        rst_n = 1'b1;
        w0 = wen_count;
        idle_wen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_wen !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) idle_wen++;
        end
        check("idle_quiet", idle_wen, 0);
        check("idle_wen_count", wen_count - w0, 0);

        preload(10'h010, 8'hA1);
        preload(10'h011, 8'hB2);
        preload(10'h012, 8'hC3);
        preload(10'h013, 8'hD4);
        preload_done();
        run_copy(10'h010, 10'h200, 4, 1'b0, 1'b0, 1'b1);
        check("copy_200", int'(mem[10'h200]), 8'hA1);
        check("copy_203", int'(mem[10'h203]), 8'hD4);

        run_copy(10'h3FE, 10'h100, 4, 1'b0, 1'b0, 1'b1);
        check("wrap_102", int'(mem[10'h102]), int'(mem[10'h000]));

        run_copy(10'h055, 10'h155, 0, 1'b0, 1'b0, 1'b1);
        run_copy(10'h020, 10'h0A0, 3, 1'b1, 1'b0, 1'b1);
        run_copy(10'h123, 10'h123, 5, 1'b0, 1'b0, 1'b1);

        for (int t = 0; t < 10; t++) begin
            src = $urandom_range(0, MSIZE - 1);
            dst = (t % 3 == 0) ? (src + $urandom_range(1, 5)) % MSIZE
                               : $urandom_range(0, MSIZE - 1);
            len = $urandom_range(1, 40);
            run_copy(src, dst, len, 1'b0, 1'b0, 1'b1);
        end

        run_copy(10'h000, 10'h200, 2047, 1'b0, 1'b0, 1'b1);

        // Reset asserted during the WRITE of byte 2 of a 4-byte copy.
        byte1 = ref_mem[10'h040];
        old2  = ref_mem[10'h301];
        @(negedge clk);
        cmd_src   = 10'h040;
        cmd_dst   = 10'h300;
        cmd_len   = 11'd4;
        cmd_valid = 1'b1;
        w0 = wen_count;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("mid_wen_before", int'(mem_wen), 1);
        rst_n = 1'b0;
        #1;
        check("mid_wen_async", int'(mem_wen), 0);
        check("mid_ready", int'(cmd_ready), 1);
        check("mid_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_wen_total", wen_count - w0, 1);
        check("mid_byte1", int'(mem[10'h300]), int'(byte1));
        check("mid_byte2", int'(mem[10'h301]), int'(old2));
        check("mid_idle", int'(cmd_ready), 1);
        ref_mem[10'h300] = byte1;
        compare_mem();

`ifdef MEM_COPY_VERIFY_EN
        bad_bank2 = 1'b1;
        run_copy(10'h050, 10'h280, 2, 1'b0, 1'b1, 1'b0);
        run_copy(10'h060, 10'h070, 3, 1'b0, 1'b0, 1'b0);
        bad_bank2 = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
